// File: rtl/contador_sincrono_crescente_pkg.sv
// Shared widths, default parameters and the binary-to-BCD helper
// for the synchronous up counter.
package contador_sincrono_crescente_pkg;

  localparam int unsigned CNT_W      = 7;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MODULO_DEF = 100;
  localparam int unsigned PRESET_DEF = 0;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } bcd_t;

  // Valid for v in 0..99, which covers every legal count value.
  function automatic bcd_t to_bcd(input logic [CNT_W-1:0] v);
    bcd_t r;
    r.tens  = BCD_W'(v / CNT_W'(10));
    r.units = BCD_W'(v % CNT_W'(10));
    return r;
  endfunction

endpackage

// File: rtl/contador_sincrono_crescente_if.sv
// Control and count bus of the synchronous up counter; the controller
// side drives pr/en/ld/d, the counter side drives the count outputs.
interface contador_sincrono_crescente_if;
  import contador_sincrono_crescente_pkg::*;

  logic             pr;
  logic             en;
  logic             ld;
  logic [CNT_W-1:0] d;
  logic [CNT_W-1:0] q;
  logic [BCD_W-1:0] units;
  logic [BCD_W-1:0] tens;
  logic             tc;
  logic             err;

  modport master (
    output pr, en, ld, d,
    input  q, units, tens, tc, err
  );

  modport slave (
    input  pr, en, ld, d,
    output q, units, tens, tc, err
  );

endinterface

// File: rtl/contador_sincrono_crescente_bcd_digit_counter.sv
// One decimal digit: synchronous clear, parallel load, increment with
// 9 -> 0 rollover and a carry flag for the next digit.
module bcd_digit_counter
  import contador_sincrono_crescente_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_value,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);

  localparam logic [BCD_W-1:0] DIGIT_MAX = BCD_W'(9);

  assign carry = inc && (digit == DIGIT_MAX);

  always_ff @(posedge clk) begin
    if (clr) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_value;
    end else if (inc) begin
      digit <= (digit == DIGIT_MAX) ? '0 : digit + BCD_W'(1);
    end
  end

endmodule

// File: rtl/contador_sincrono_crescente.sv
// Modulo-N synchronous up counter with preset, parallel load, terminal
// count, illegal-load flag and a BCD copy of the count kept in lockstep.
module contador_sincrono_crescente
  import contador_sincrono_crescente_pkg::*;
#(
  parameter int unsigned MODULO = MODULO_DEF,
  parameter int unsigned PRESET = PRESET_DEF
) (
  input  logic                          clk,
  input  logic                          clr,
  contador_sincrono_crescente_if.slave  bus
);

  if ((MODULO < 2) || (MODULO > 100)) begin : g_bad_modulo
    $fatal(1, "contador_sincrono_crescente: MODULO must be in 2..100");
  end
  if (PRESET >= MODULO) begin : g_bad_preset
    $fatal(1, "contador_sincrono_crescente: PRESET must be in 0..MODULO-1");
  end

  localparam logic [CNT_W-1:0] Q_MAX    = CNT_W'(MODULO - 1);
  localparam logic [CNT_W-1:0] Q_PRESET = CNT_W'(PRESET);

  logic [CNT_W-1:0] q_r;
  logic [CNT_W-1:0] q_next;
  logic             err_r;
  logic             err_next;
  logic             at_max;
  logic             ld_ok;
  logic             load_c;
  logic             inc_c;
  logic [CNT_W-1:0] load_val;
  bcd_t             load_bcd;
  logic [BCD_W-1:0] units_digit;
  logic [BCD_W-1:0] tens_digit;
  logic             units_carry;
  logic             unused_tens_carry;

  assign at_max   = (q_r == Q_MAX);
  assign ld_ok    = (bus.d <= Q_MAX);
  assign load_bcd = to_bcd(load_val);

  // Next count and digit controls; wrap is a load of 0 so both digits
  // clear together regardless of MODULO.
  always_comb begin
    q_next   = q_r;
    err_next = 1'b0;
    load_c   = 1'b0;
    inc_c    = 1'b0;
    load_val = '0;
    if (bus.pr) begin
      q_next   = Q_PRESET;
      load_c   = 1'b1;
      load_val = Q_PRESET;
    end else if (bus.ld) begin
      if (ld_ok) begin
        q_next   = bus.d;
        load_c   = 1'b1;
        load_val = bus.d;
      end else begin
        err_next = 1'b1;
      end
    end else if (bus.en) begin
      if (at_max) begin
        q_next = '0;
        load_c = 1'b1;
      end else begin
        q_next = q_r + CNT_W'(1);
        inc_c  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_r   <= '0;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_next;
      err_r <= err_next;
    end
  end

  bcd_digit_counter u_units (
    .clk        (clk),
    .clr        (clr),
    .load       (load_c),
    .load_value (load_bcd.units),
    .inc        (inc_c),
    .digit      (units_digit),
    .carry      (units_carry)
  );

  // Tens never passes 9: the count wraps via load before q reaches 100.
  bcd_digit_counter u_tens (
    .clk        (clk),
    .clr        (clr),
    .load       (load_c),
    .load_value (load_bcd.tens),
    .inc        (units_carry),
    .digit      (tens_digit),
    .carry      (unused_tens_carry)
  );

  assign bus.q     = q_r;
  assign bus.err   = err_r;
  assign bus.units = units_digit;
  assign bus.tens  = tens_digit;
  assign bus.tc    = at_max && bus.en;

endmodule

// File: tb/tb_contador_sincrono_crescente.sv
// Directed bench for contador_sincrono_crescente: a MODULO=100 instance and
// a MODULO=10/PRESET=7 instance, with a per-cycle q == tens*10+units check.
module tb_contador_sincrono_crescente;
  import contador_sincrono_crescente_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   inv_on = 1'b0;

  always #5 clk = ~clk;

  contador_sincrono_crescente_if bus ();
  contador_sincrono_crescente_if bus2 ();

  contador_sincrono_crescente #(.MODULO(100), .PRESET(0)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  contador_sincrono_crescente #(.MODULO(10), .PRESET(7)) u_dut10 (
    .clk (clk),
    .clr (clr),
    .bus (bus2)
  );

  // BCD digits must always agree with the binary count.
  always @(negedge clk) begin
    if (inv_on) begin
      checks++;
      if (int'(bus.q) != int'(bus.tens) * 10 + int'(bus.units)) begin
        errors++;
        $display("FAIL inv_bcd_m100: q=%0d tens=%0d units=%0d", bus.q, bus.tens, bus.units);
      end
      checks++;
      if (int'(bus2.q) != int'(bus2.tens) * 10 + int'(bus2.units)) begin
        errors++;
        $display("FAIL inv_bcd_m10: q=%0d tens=%0d units=%0d", bus2.q, bus2.tens, bus2.units);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.q !== 7'd0 || bus.units !== 4'd0 || bus.tens !== 4'd0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_m100: q=%0d u=%0d t=%0d err=%b want 0/0/0/0", bus.q, bus.units, bus.tens, bus.err);
    end
    checks++;
    if (bus2.q !== 7'd0 || bus2.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_m10: q=%0d err=%b want 0/0", bus2.q, bus2.err);
    end
    inv_on = 1'b1;
    clr    = 1'b0;
    bus.en = 1'b1;
    repeat (12) tick();
    bus.en = 1'b0;
    checks++;
    if (bus.q !== 7'd12 || bus.tens !== 4'd1 || bus.units !== 4'd2 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL count12: q=%0d t=%0d u=%0d err=%b want 12/1/2/0", bus.q, bus.tens, bus.units, bus.err);
    end
  endtask

  task automatic test_load_wrap();
    bus.ld = 1'b1;
    bus.d  = 7'd97;
    tick();
    bus.ld = 1'b0;
    checks++;
    if (bus.q !== 7'd97 || bus.tens !== 4'd9 || bus.units !== 4'd7) begin
      errors++;
      $display("FAIL load97: q=%0d t=%0d u=%0d want 97/9/7", bus.q, bus.tens, bus.units);
    end
    bus.en = 1'b1;
    #1;
    checks++;
    if (bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL tc_at97: tc=%b want 0", bus.tc);
    end
    tick();
    checks++;
    if (bus.q !== 7'd98 || bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL step98: q=%0d tc=%b want 98/0", bus.q, bus.tc);
    end
    tick();
    checks++;
    if (bus.q !== 7'd99 || bus.tc !== 1'b1 || bus.tens !== 4'd9 || bus.units !== 4'd9) begin
      errors++;
      $display("FAIL step99: q=%0d tc=%b t=%0d u=%0d want 99/1/9/9", bus.q, bus.tc, bus.tens, bus.units);
    end
    tick();
    checks++;
    if (bus.q !== 7'd0 || bus.tc !== 1'b0 || bus.tens !== 4'd0 || bus.units !== 4'd0) begin
      errors++;
      $display("FAIL wrap0: q=%0d tc=%b t=%0d u=%0d want 0/0/0/0", bus.q, bus.tc, bus.tens, bus.units);
    end
    bus.en = 1'b0;
    bus.ld = 1'b1;
    bus.d  = 7'd99;
    tick();
    bus.ld = 1'b0;
    #1;
    checks++;
    if (bus.q !== 7'd99 || bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL tc_gated_by_en: q=%0d tc=%b want 99/0", bus.q, bus.tc);
    end
  endtask

  task automatic test_illegal_load();
    bus.ld = 1'b1;
    bus.d  = 7'd5;
    tick();
    bus.d  = 7'd100;
    tick();
    bus.ld = 1'b0;
    checks++;
    if (bus.q !== 7'd5 || bus.err !== 1'b1 || bus.tens !== 4'd0 || bus.units !== 4'd5) begin
      errors++;
      $display("FAIL bad_load100: q=%0d err=%b t=%0d u=%0d want 5/1/0/5", bus.q, bus.err, bus.tens, bus.units);
    end
    tick();
    checks++;
    if (bus.q !== 7'd5 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle: q=%0d err=%b want 5/0", bus.q, bus.err);
    end
    bus.ld = 1'b1;
    bus.d  = 7'd127;
    bus.en = 1'b1;
    tick();
    bus.ld = 1'b0;
    bus.en = 1'b0;
    checks++;
    if (bus.q !== 7'd5 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL bad_load127_en: q=%0d err=%b want 5/1", bus.q, bus.err);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear2: err=%b want 0", bus.err);
    end
  endtask

  task automatic test_priority();
    bus.ld = 1'b1;
    bus.d  = 7'd33;
    tick();
    bus.pr = 1'b1;
    bus.d  = 7'd40;
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.q !== 7'd0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL pr_over_ld: q=%0d err=%b want 0/0", bus.q, bus.err);
    end
    bus.d = 7'd120;
    tick();
    bus.pr = 1'b0;
    checks++;
    if (bus.q !== 7'd0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL pr_masks_err: q=%0d err=%b want 0/0", bus.q, bus.err);
    end
    bus.d = 7'd20;
    tick();
    checks++;
    if (bus.q !== 7'd20 || bus.tens !== 4'd2 || bus.units !== 4'd0) begin
      errors++;
      $display("FAIL ld_over_en: q=%0d t=%0d u=%0d want 20/2/0", bus.q, bus.tens, bus.units);
    end
    clr   = 1'b1;
    bus.d = 7'd110;
    tick();
    clr = 1'b0;
    checks++;
    if (bus.q !== 7'd0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL clr_over_all: q=%0d err=%b want 0/0", bus.q, bus.err);
    end
    bus.en = 1'b0;
    bus.d  = 7'd99;
    tick();
    bus.d  = 7'd10;
    bus.en = 1'b1;
    #1;
    checks++;
    if (bus.tc !== 1'b1) begin
      errors++;
      $display("FAIL tc_not_delayed_by_ld: tc=%b want 1", bus.tc);
    end
    tick();
    bus.ld = 1'b0;
    bus.en = 1'b0;
    checks++;
    if (bus.q !== 7'd10 || bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL ld_at_max: q=%0d tc=%b want 10/0", bus.q, bus.tc);
    end
  endtask

  task automatic test_hold();
    bus.ld = 1'b1;
    bus.d  = 7'd42;
    tick();
    bus.ld = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.q !== 7'd42 || bus.tens !== 4'd4 || bus.units !== 4'd2 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL hold42: q=%0d t=%0d u=%0d err=%b want 42/4/2/0", bus.q, bus.tens, bus.units, bus.err);
    end
  endtask

  task automatic test_clr_mid_count();
    bus.ld = 1'b1;
    bus.d  = 7'd56;
    tick();
    bus.ld = 1'b0;
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.q !== 7'd57) begin
      errors++;
      $display("FAIL count57: q=%0d want 57", bus.q);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (bus.q !== 7'd0 || bus.tens !== 4'd0 || bus.units !== 4'd0) begin
      errors++;
      $display("FAIL clr_mid: q=%0d t=%0d u=%0d want 0/0/0", bus.q, bus.tens, bus.units);
    end
    tick();
    bus.en = 1'b0;
    checks++;
    if (bus.q !== 7'd1) begin
      errors++;
      $display("FAIL resume1: q=%0d want 1", bus.q);
    end
  endtask

  task automatic test_modulo10();
    clr = 1'b1;
    tick();
    clr     = 1'b0;
    bus2.pr = 1'b1;
    tick();
    bus2.pr = 1'b0;
    checks++;
    if (bus2.q !== 7'd7 || bus2.units !== 4'd7 || bus2.tens !== 4'd0) begin
      errors++;
      $display("FAIL preset7: q=%0d u=%0d t=%0d want 7/7/0", bus2.q, bus2.units, bus2.tens);
    end
    clr = 1'b1;
    tick();
    clr     = 1'b0;
    bus2.en = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      #1;
      checks++;
      if (bus2.tc !== ((k % 10) == 0)) begin
        errors++;
        $display("FAIL tc_m10_edge%0d: tc=%b want %b", k, bus2.tc, ((k % 10) == 0));
      end
      tick();
    end
    bus2.en = 1'b0;
    checks++;
    if (bus2.q !== 7'd5 || bus2.tens !== 4'd0 || bus2.units !== 4'd5) begin
      errors++;
      $display("FAIL m10_after25: q=%0d t=%0d u=%0d want 5/0/5", bus2.q, bus2.tens, bus2.units);
    end
    bus2.ld = 1'b1;
    bus2.d  = 7'd10;
    tick();
    checks++;
    if (bus2.q !== 7'd5 || bus2.err !== 1'b1) begin
      errors++;
      $display("FAIL m10_bad_load10: q=%0d err=%b want 5/1", bus2.q, bus2.err);
    end
    bus2.d = 7'd9;
    tick();
    bus2.ld = 1'b0;
    checks++;
    if (bus2.q !== 7'd9 || bus2.err !== 1'b0 || bus2.units !== 4'd9) begin
      errors++;
      $display("FAIL m10_load9: q=%0d err=%b u=%0d want 9/0/9", bus2.q, bus2.err, bus2.units);
    end
  endtask

  initial begin
    bus.pr  = 1'b0;
    bus.en  = 1'b0;
    bus.ld  = 1'b0;
    bus.d   = '0;
    bus2.pr = 1'b0;
    bus2.en = 1'b0;
    bus2.ld = 1'b0;
    bus2.d  = '0;
    test_reset();
    test_load_wrap();
    test_illegal_load();
    test_priority();
    test_hold();
    test_clr_mid_count();
    test_modulo10();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/contador_sincrono_crescente.md
CONTADOR_SINCRONO_CRESCENTE -- requirements
Module: contador_sincrono_crescente

Interface
REQ-001 The block SHALL have parameter MODULO, default 100, meaning count range 0..MODULO-1, legal range 2..100.
REQ-002 The block SHALL have parameter PRESET, default 0, meaning the value loaded by pr, legal range 0..MODULO-1.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit, the reset; synchronous, active-high.
REQ-005 The block SHALL have port pr, input, 1 bit, synchronous preset to PRESET.
REQ-006 The block SHALL have port en, input, 1 bit, count enable.
REQ-007 The block SHALL have port ld, input, 1 bit, synchronous parallel-load strobe.
REQ-008 The block SHALL have port d, input, 7 bits, the parallel-load value, unsigned.
REQ-009 The block SHALL have port q, output, 7 bits, the registered binary count, unsigned.
REQ-010 The block SHALL have port units, output, 4 bits, the registered BCD units digit of q.
REQ-011 The block SHALL have port tens, output, 4 bits, the registered BCD tens digit of q.
REQ-012 The block SHALL have port tc, output, 1 bit, terminal count; combinational, high when q==MODULO-1 and en==1.
REQ-013 The block SHALL have port err, output, 1 bit, registered; pulses for one cycle after an illegal load.

Function
REQ-014 The priority per rising edge SHALL be clr > pr > ld > en > hold.
REQ-015 pr=1 (clr=0) SHALL set q=PRESET, with units and tens equal to the BCD of PRESET, on the next edge.
REQ-016 ld=1 with d<=MODULO-1 (clr=0, pr=0) SHALL set q=d, with units and tens equal to the BCD of d, on the next edge.
REQ-017 ld=1 with d>=MODULO SHALL leave q, units and tens unchanged and set err=1 for exactly the next cycle.
REQ-018 err SHALL be 0 in every other cycle, including cycles where pr or clr override ld.
REQ-019 en=1 with no higher-priority input SHALL increment q by 1 per edge.
REQ-020 At q==MODULO-1, en=1 SHALL wrap q to 0 on the next edge, with units=0 and tens=0.
REQ-021 units SHALL increment with q; at units==9 it SHALL go to 0 and tens SHALL increment, both on the same edge.
REQ-022 At all times, q SHALL equal tens*10+units, checked every cycle.
REQ-023 en=0 with no other active input SHALL hold q, units and tens.
REQ-024 tc SHALL depend only on the current q and en; it SHALL not be delayed by ld or pr in the same cycle.
REQ-025 Count latency SHALL be exactly one edge from input to q; no pipelining.

Reset
REQ-026 clr=1 SHALL set q=0, units=0, tens=0 and err=0 on the next edge, regardless of pr, ld and en.
REQ-027 clr asserted mid-count SHALL take effect on the next edge; counting resumes from 0 the first edge after clr deasserts with en=1.
REQ-028 There SHALL be no asynchronous reset or preset path.

Structure
REQ-029 A shared package/header SHALL hold the width constant (7), BCD digit width (4), and default MODULO/PRESET.
REQ-030 The BCD digit sub-module SHALL be named bcd_digit_counter, with inputs clk, clr, load, load value, inc, and outputs digit and carry; it SHALL be instantiated twice (units, tens).
REQ-031 Parameter legality (REQ-001, REQ-002) SHALL be checked at elaboration with a fatal error.

Verification
REQ-032 clr=1 for 1 edge, then en=1 for 12 edges -> q=12, tens=1, units=2, err=0.
REQ-033 ld=1, d=97, then en=1 for 3 edges -> q sequence 97, 98, 99, 0; tc=1 only while q=99; tens/units=9/9 then 0/0.
REQ-034 ld=1, d=100 while q=5 -> q stays 5; err=1 for exactly one cycle.
REQ-035 pr=1, ld=1, d=40, en=1 in the same cycle (PRESET=0) -> q=0; err=0.
REQ-036 Counting at q=57, clr=1 for one edge with en=1 -> q=0; the next edge gives q=1.
REQ-037 MODULO=10, en=1 for 25 edges from reset -> q=5, tens=0; tc high on edges 10 and 20.
